// File: rtl/tick_divider_bank_if.sv
// Half-period load handshake for tick_divider_bank: the requester drives
// channel/value/valid, the divider bank answers with a combinational ready.
interface tick_divider_bank_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 32
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_half;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_half,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_half,
        output cfg_ready
    );
endinterface

// File: rtl/tick_divider_bank.sv
// Bank of independent programmable dividers: each channel produces a 50%-duty
// divclk and a one-cycle tick on every divclk rise, with glitch-free reloads.
module tick_divider_bank #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = 500_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                phase_clr,
    tick_divider_bank_if.slave  cfg,
    output logic [CHANNELS-1:0] divclk,
    output logic [CHANNELS-1:0] tick
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CNT_W-1:0]    cnt   [CHANNELS];
    logic [CNT_W-1:0]    half  [CHANNELS];
    logic [CNT_W-1:0]    stage [CHANNELS];
    logic [CNT_W-1:0]    eh    [CHANNELS];
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] load_sel;

    // A programmed half of zero behaves as one so the counter always terminates.
    always_comb begin
        wrap = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            eh[i]   = (half[i] == '0) ? CNT_W'(1) : half[i];
            wrap[i] = (cnt[i] == eh[i] - CNT_W'(1));
        end
    end

    // Out-of-range channel numbers match no entry, so they see ready=1 and are dropped.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                cfg.cfg_ready = ~pend[i];
            end
        end
    end

    always_comb begin
        load_sel = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            load_sel[i] = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i]   <= '0;
                half[i]  <= CNT_W'(DEFAULT_HALF);
                stage[i] <= '0;
            end
            pend   <= '0;
            divclk <= '0;
            tick   <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (phase_clr) begin
                    cnt[i]    <= '0;
                    divclk[i] <= 1'b0;
                    tick[i]   <= 1'b0;
                    if (pend[i]) begin
                        half[i] <= stage[i];
                        pend[i] <= 1'b0;
                    end
                end else if (en[i] && wrap[i]) begin
                    // Toggle on the old half; the staged value governs the next half-period.
                    cnt[i]    <= '0;
                    divclk[i] <= ~divclk[i];
                    tick[i]   <= ~divclk[i];
                    if (pend[i]) begin
                        half[i] <= stage[i];
                        pend[i] <= 1'b0;
                    end
                end else if (en[i]) begin
                    cnt[i]  <= cnt[i] + CNT_W'(1);
                    tick[i] <= 1'b0;
                end else begin
                    tick[i] <= 1'b0;
                end

                // Accept only happens while pend is clear, so it never collides with an apply.
                if (load_sel[i]) begin
                    stage[i] <= cfg.cfg_half;
                    pend[i]  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tick_divider_bank.sv
// Randomized and directed bench for tick_divider_bank against a countdown model
// of each channel's time-to-next-toggle.
module tb_tick_divider_bank;
    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 8;
    localparam int unsigned DH  = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] en = '0;
    logic           phase_clr = 1'b0;
    logic [NCH-1:0] divclk;
    logic [NCH-1:0] tick;

    tick_divider_bank_if #(.CHANNELS(NCH), .CNT_W(CW)) cfg_if ();

    tick_divider_bank #(
        .CHANNELS    (NCH),
        .CNT_W       (CW),
        .DEFAULT_HALF(DH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .phase_clr(phase_clr),
        .cfg      (cfg_if),
        .divclk   (divclk),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference: cycles remaining until the next toggle, per channel.
    int m_half  [NCH];
    int m_stage [NCH];
    int m_rem   [NCH];
    bit m_pend  [NCH];
    bit m_lvl   [NCH];
    bit m_tk    [NCH];

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic bit m_ready();
        int ch;
        ch = int'(cfg_if.cfg_ch);
        if (ch >= NCH) return 1'b1;
        return !m_pend[ch];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit acc;
        int ch;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_half[i]  = DH;
                m_stage[i] = 0;
                m_pend[i]  = 1'b0;
                m_lvl[i]   = 1'b0;
                m_tk[i]    = 1'b0;
                m_rem[i]   = eff(DH);
            end
        end else begin
            acc = cfg_if.cfg_valid && m_ready();
            ch  = int'(cfg_if.cfg_ch);
            for (int i = 0; i < NCH; i++) begin
                if (phase_clr) begin
                    if (m_pend[i]) begin
                        m_half[i] = m_stage[i];
                        m_pend[i] = 1'b0;
                    end
                    m_lvl[i] = 1'b0;
                    m_tk[i]  = 1'b0;
                    m_rem[i] = eff(m_half[i]);
                end else if (en[i]) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_tk[i]  = !m_lvl[i];
                        m_lvl[i] = !m_lvl[i];
                        if (m_pend[i]) begin
                            m_half[i] = m_stage[i];
                            m_pend[i] = 1'b0;
                        end
                        m_rem[i] = eff(m_half[i]);
                    end else begin
                        m_tk[i] = 1'b0;
                    end
                end else begin
                    m_tk[i] = 1'b0;
                end
                if (acc && ch == i) begin
                    m_stage[i] = int'(cfg_if.cfg_half);
                    m_pend[i]  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        for (int i = 0; i < NCH; i++) begin
            if (divclk[i] !== m_lvl[i]) begin
                errors++;
                $display("FAIL divclk[%0d] t=%0t got %b want %b", i, $time, divclk[i], m_lvl[i]);
            end
            if (tick[i] !== m_tk[i]) begin
                errors++;
                $display("FAIL tick[%0d] t=%0t got %b want %b", i, $time, tick[i], m_tk[i]);
            end
        end
        if (cfg_if.cfg_ready !== m_ready()) begin
            errors++;
            $display("FAIL cfg_ready t=%0t got %b want %b", $time, cfg_if.cfg_ready, m_ready());
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        en               = '0;
        phase_clr        = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_half  = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_divclk", 32'(divclk), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 1);

        // Free-running at the default half of 3.
        en = '1;
        for (int e = 1; e <= 16; e++) begin
            step();
            case (e)
                2:  chk("t1_div_e2", 32'(divclk[0]), 0);
                3:  begin chk("t1_div_e3", 32'(divclk[0]), 1); chk("t1_tick_e3", 32'(tick[0]), 1); end
                4:  begin chk("t1_div_e4", 32'(divclk[0]), 1); chk("t1_tick_e4", 32'(tick[0]), 0); end
                6:  begin chk("t1_div_e6", 32'(divclk[0]), 0); chk("t1_tick_e6", 32'(tick[0]), 0); end
                9:  chk("t1_tick_e9", 32'(tick[0]), 1);
                12: chk("t1_div_e12", 32'(divclk[0]), 0);
                15: chk("t1_tick_e15", 32'(tick[1]), 1);
                default: ;
            endcase
        end

        // Reload mid half-period, then half=0 plus phase_clr.
        do_reset();
        en = '1;
        for (int e = 1; e <= 11; e++) begin
            step();
            case (e)
                3: begin
                    chk("t2_ready_e3", 32'(cfg_if.cfg_ready), 1);
                    cfg_if.cfg_valid = 1'b1;
                    cfg_if.cfg_ch    = 2'd0;
                    cfg_if.cfg_half  = 8'd5;
                end
                4: begin
                    cfg_if.cfg_valid = 1'b0;
                    #1 chk("t2_ready_e4", 32'(cfg_if.cfg_ready), 0);
                end
                5:  chk("t2_ready_e5", 32'(cfg_if.cfg_ready), 0);
                6:  begin chk("t2_div_e6", 32'(divclk[0]), 0); chk("t2_ready_e6", 32'(cfg_if.cfg_ready), 1); end
                10: chk("t2_div_e10", 32'(divclk[0]), 0);
                11: begin chk("t2_div_e11", 32'(divclk[0]), 1); chk("t2_tick_e11", 32'(tick[0]), 1); end
                default: ;
            endcase
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd1;
        cfg_if.cfg_half  = 8'd0;
        step();
        cfg_if.cfg_valid = 1'b0;
        phase_clr        = 1'b1;
        step();
        phase_clr = 1'b0;
        chk("t3_clr_div", 32'(divclk), 0);
        chk("t3_clr_tick", 32'(tick), 0);
        step();
        chk("t3_div1_a", 32'(divclk[1]), 1);
        chk("t3_tick1_a", 32'(tick[1]), 1);
        step();
        chk("t3_div1_b", 32'(divclk[1]), 0);
        chk("t3_tick1_b", 32'(tick[1]), 0);
        step();
        chk("t3_div1_c", 32'(divclk[1]), 1);
        chk("t3_div2_c", 32'(divclk[2]), 1);
        chk("t3_div0_c", 32'(divclk[0]), 0);

        // Out-of-range channel is accepted and dropped.
        cfg_if.cfg_ch    = 2'd3;
        cfg_if.cfg_half  = 8'd9;
        cfg_if.cfg_valid = 1'b1;
        #1 chk("oor_ready", 32'(cfg_if.cfg_ready), 1);
        step();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = 2'd0;

        // Enable held low for four cycles stretches the half-period.
        do_reset();
        en = '1;
        step();
        en[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_tick_hold", 32'(tick[0]), 0);
        end
        en[0] = 1'b1;
        step();
        chk("t4_div_e6", 32'(divclk[0]), 0);
        step();
        chk("t4_div_e7", 32'(divclk[0]), 1);
        chk("t4_tick_e7", 32'(tick[0]), 1);

        // phase_clr coincides with the ch0 wrap at edge 10.
        step();
        step();
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        chk("t5_div_clr", 32'(divclk), 0);
        chk("t5_tick_clr", 32'(tick), 0);
        step();
        step();
        chk("t5_div_pre", 32'(divclk), 0);
        step();
        chk("t5_div_all", 32'(divclk), 32'(3'b111));
        chk("t5_tick_all", 32'(tick), 32'(3'b111));

        // Asynchronous reset with a load pending.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_half  = 8'd7;
        step();
        cfg_if.cfg_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_div", 32'(divclk), 0);
        chk("t6_tick", 32'(tick), 0);
        chk("t6_ready", 32'(cfg_if.cfg_ready), 1);
        step();
        rst_n = 1'b1;
        en    = '1;
        step();
        step();
        chk("t6_div_e2", 32'(divclk[0]), 0);
        step();
        chk("t6_div_e3", 32'(divclk[0]), 1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!rst_n) rst_n = 1'b1;
            for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 99) < 85);
            phase_clr        = ($urandom_range(0, 99) < 2);
            cfg_if.cfg_valid = ($urandom_range(0, 99) < 30);
            cfg_if.cfg_ch    = 2'($urandom_range(0, 3));
            cfg_if.cfg_half  = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rnd_arst_div", 32'(divclk), 0);
                chk("rnd_arst_tick", 32'(tick), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
